trig_lut_engine: RTL and testbench

Parametrised successor to the single-function secant LUT. One engine evaluates sin, cos, tan, cot, sec or csc of an unsigned integer-degree angle of any width and returns an IEEE-754 double. Multi-cycle modulo-360 reduction, quadrant folding onto three 0..90 degree double tables, and valid/ready handshakes on both sides. Sits between the angle/command front end and the double FPU result path.

---
 rtl/trig_lut_if.sv | 36 +++
 rtl/trig_lut_engine.sv | 214 +++++++++++++++++++++
 tb/tb_trig_lut_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/trig_lut_if.sv
// Request/result handshake bundle for trig_lut_engine.
// TRIG_POLE_FLAG_EN adds the out_pole result flag.
interface trig_lut_if #(
  parameter int ANGLE_W = 32,
  parameter int TAG_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [ANGLE_W-1:0] in_angle;
  logic [2:0]         in_func;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_err;
`ifdef TRIG_POLE_FLAG_EN
  logic               out_pole;
`endif

  modport master (
    output in_valid, in_angle, in_func, in_tag, out_ready,
`ifdef TRIG_POLE_FLAG_EN
    input  out_pole,
`endif
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_angle, in_func, in_tag, out_ready,
`ifdef TRIG_POLE_FLAG_EN
    output out_pole,
`endif
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/trig_lut_engine.sv
// Integer-degree sin/cos/tan/cot/sec/csc engine returning IEEE-754 doubles.
// Optional macro TRIG_POLE_FLAG_EN adds the registered out_pole flag.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a request
// REDUCE | one restoring mod-360 step per cycle, k counts down to 0
// LOOKUP | fold residue into quadrant, read table, register result
// OUT    | hold result until out_ready
module trig_lut_engine #(
  parameter int ANGLE_W = 32,
  parameter int TAG_W   = 4
) (
  input logic         clk,
  input logic         reset_n,
  trig_lut_if.slave   bus
);

  localparam real         PI_R     = 3.14159265358979323846;
  localparam logic [63:0] DBL_INF  = 64'h7FF0000000000000;
  localparam logic [63:0] DBL_NAN  = 64'h7FF8000000000000;
  localparam logic [63:0] DBL_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] DBL_HALF = 64'h3FE0000000000000;
  localparam logic [63:0] DBL_TWO  = 64'h4000000000000000;

  // Elaboration-time sine in degrees; angles above 45 use the cosine series
  // of the complement so the series argument stays below pi/4.
  function automatic real sin_deg(input int a);
    real x;
    real t;
    real s;
    int  b;
    b = (a > 45) ? 90 - a : a;
    x = real'(b) * PI_R / 180.0;
    if (a > 45) begin
      s = 1.0;
      t = 1.0;
      for (int n = 1; n <= 12; n++) begin
        t = -t * x * x / real'((2 * n - 1) * (2 * n));
        s = s + t;
      end
    end else begin
      s = x;
      t = x;
      for (int n = 1; n <= 12; n++) begin
        t = -t * x * x / real'((2 * n) * (2 * n + 1));
        s = s + t;
      end
    end
    return s;
  endfunction

  // Exactly representable entries are pinned so they never drift by an ulp.
  function automatic logic [63:0] tbl_entry(input int kind, input int a);
    logic [63:0] e;
    case (kind)
      0:       e = (a == 0)  ? 64'h0 :
                   (a == 30) ? DBL_HALF :
                   (a == 90) ? DBL_ONE : $realtobits(sin_deg(a));
      1:       e = (a == 0)  ? 64'h0 :
                   (a == 45) ? DBL_ONE :
                   (a == 90) ? DBL_INF : $realtobits(sin_deg(a) / sin_deg(90 - a));
      default: e = (a == 0)  ? DBL_INF :
                   (a == 30) ? DBL_TWO :
                   (a == 90) ? DBL_ONE : $realtobits(1.0 / sin_deg(a));
    endcase
    return e;
  endfunction

  logic [63:0] sin_t [0:90];
  logic [63:0] tan_t [0:90];
  logic [63:0] csc_t [0:90];

  for (genvar i = 0; i <= 90; i++) begin : g_tbl
    localparam logic [63:0] SIN_E = tbl_entry(0, i);
    localparam logic [63:0] TAN_E = tbl_entry(1, i);
    localparam logic [63:0] CSC_E = tbl_entry(2, i);
    assign sin_t[i] = SIN_E;
    assign tan_t[i] = TAN_E;
    assign csc_t[i] = CSC_E;
  end

  typedef enum logic [1:0] {IDLE, REDUCE, LOOKUP, OUT} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ANGLE_W-1:0] r;
  logic [ANGLE_W-1:0] step;
  logic [4:0]         k;
  logic [2:0]         func;
  logic [TAG_W-1:0]   tag;
  logic               out_valid;
  logic [63:0]        out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_err;
  logic               pole;

  logic [8:0]  r9;
  logic [1:0]  q;
  logic [6:0]  a;
  logic [6:0]  c;
  logic [6:0]  idx;
  logic        swap;
  logic        neg;
  logic        illegal;
  logic [63:0] entry;
  logic [63:0] result;

  assign step = ANGLE_W'(360) << k;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)
                 state_nxt = (bus.in_angle >= ANGLE_W'(360)) ? REDUCE : LOOKUP;
      REDUCE:  if (k == 5'd0) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fold the residue (< 360) into a quadrant and pick index/sign/table.
  always_comb begin
    r9 = r[8:0];
    q  = 2'd0;
    a  = r9[6:0];
    if (r9 >= 9'd270) begin
      q = 2'd3;
      a = 7'(r9 - 9'd270);
    end else if (r9 >= 9'd180) begin
      q = 2'd2;
      a = 7'(r9 - 9'd180);
    end else if (r9 >= 9'd90) begin
      q = 2'd1;
      a = 7'(r9 - 9'd90);
    end
    c       = 7'd90 - a;
    swap    = (func == 3'd1) || (func == 3'd3) || (func == 3'd4);
    idx     = (q[0] ^ swap) ? c : a;
    illegal = (func > 3'd5);
    case (func)
      3'd0, 3'd5: neg = q[1];
      3'd1, 3'd4: neg = q[1] ^ q[0];
      default:    neg = q[0];
    endcase
    case (func)
      3'd0, 3'd1: entry = sin_t[idx];
      3'd2, 3'd3: entry = tan_t[idx];
      default:    entry = csc_t[idx];
    endcase
    pole = !illegal && (entry == DBL_INF);
    if (illegal)                 result = DBL_NAN;
    else if (pole)               result = DBL_INF;
    else if (entry[62:0] == '0)  result = 64'h0;
    else                         result = {neg, entry[62:0]};
  end

`ifdef TRIG_POLE_FLAG_EN
  logic out_pole;
  assign bus.out_pole = out_pole;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r         <= '0;
      k         <= '0;
      func      <= '0;
      tag       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
`ifdef TRIG_POLE_FLAG_EN
      out_pole  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          r    <= bus.in_angle;
          func <= bus.in_func;
          tag  <= bus.in_tag;
          k    <= 5'(ANGLE_W - 9);
        end
        REDUCE: begin
          if (r >= step) r <= r - step;
          k <= k - 5'd1;
        end
        LOOKUP: begin
          out_valid <= 1'b1;
          out_data  <= result;
          out_tag   <= tag;
          out_err   <= illegal;
`ifdef TRIG_POLE_FLAG_EN
          out_pole  <= pole;
`endif
        end
        OUT: if (bus.out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_tag   = out_tag;
  assign bus.out_err   = out_err;

endmodule

// File: tb/tb_trig_lut_engine.sv
// Self-checking bench for trig_lut_engine: directed cases plus random requests
// compared against a real-arithmetic reference of the trig functions.
module tb_trig_lut_engine;
  localparam int          ANGLE_W = 32;
  localparam int          TAG_W   = 4;
  localparam logic [63:0] INF     = 64'h7FF0000000000000;
  localparam logic [63:0] NAN     = 64'h7FF8000000000000;
  localparam real         PI_R    = 3.14159265358979323846;
  // degree->radian rounding in the reference costs many ulps next to poles
  localparam int unsigned TOL     = 65536;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  trig_lut_if #(.ANGLE_W(ANGLE_W), .TAG_W(TAG_W)) bus ();
  trig_lut_engine #(.ANGLE_W(ANGLE_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp, input int unsigned tol = 0);
    logic        ok;
    longint      d;
    n_cmp++;
    ok = (got === exp);
    if (!ok && tol > 0 && got[63] == exp[63] && got[62:52] != 11'h7FF &&
        exp[62:52] != 11'h7FF && got[62:0] != '0 && exp[62:0] != '0) begin
      d  = longint'({1'b0, got[62:0]}) - longint'({1'b0, exp[62:0]});
      ok = (d <= longint'(tol)) && (d >= -longint'(tol));
    end
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] ang, input int fn);
    int unsigned res;
    int unsigned m;
    real         s;
    real         cv;
    real         rad;
    real         v;
    res = ang % 32'd360;
    if (fn > 5) return NAN;
    if (res % 90 == 0) begin
      m  = res / 90;
      s  = (m == 1) ? 1.0 : (m == 3) ? -1.0 : 0.0;
      cv = (m == 0) ? 1.0 : (m == 2) ? -1.0 : 0.0;
      case (fn)
        0: v = s;
        1: v = cv;
        2: begin if (cv == 0.0) return INF; v = 0.0; end
        3: begin if (s == 0.0) return INF; v = 0.0; end
        4: begin if (cv == 0.0) return INF; v = 1.0 / cv; end
        default: begin if (s == 0.0) return INF; v = 1.0 / s; end
      endcase
      return (v == 0.0) ? 64'h0 : $realtobits(v);
    end
    rad = real'(res) * PI_R / 180.0;
    case (fn)
      0: v = $sin(rad);
      1: v = $cos(rad);
      2: v = $tan(rad);
      3: v = 1.0 / $tan(rad);
      4: v = 1.0 / $cos(rad);
      default: v = 1.0 / $sin(rad);
    endcase
    return $realtobits(v);
  endfunction

  task automatic send(input logic [31:0] ang, input logic [2:0] fn,
                      input logic [TAG_W-1:0] tg, output int lat);
    int waited;
    bus.in_angle = ang;
    bus.in_func  = fn;
    bus.in_tag   = tg;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic txn(input string name, input logic [31:0] ang, input logic [2:0] fn,
                     input logic [TAG_W-1:0] tg, input logic [63:0] exp,
                     input int unsigned tol);
    int lat;
    send(ang, fn, tg, lat);
    check({name, "_lat"}, 64'(lat), (ang < 360) ? 64'd1 : 64'(ANGLE_W - 7));
    check({name, "_data"}, bus.out_data, exp, tol);
    check({name, "_err"}, 64'(bus.out_err), 64'(fn > 3'd5));
    check({name, "_tag"}, 64'(bus.out_tag), 64'(tg));
`ifdef TRIG_POLE_FLAG_EN
    check({name, "_pole"}, 64'(bus.out_pole), 64'(exp == INF));
`endif
    drain();
  endtask

  initial begin
    logic [63:0]      d0;
    logic [31:0]      ang;
    logic [2:0]       fn;
    logic [TAG_W-1:0] tg;
    int               lat;
    int               seen;

    bus.in_valid  = 1'b0;
    bus.in_angle  = '0;
    bus.in_func   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'h0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
`ifdef TRIG_POLE_FLAG_EN
    check("rst_out_pole", 64'(bus.out_pole), 64'd0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;

    txn("sin30",   32'd30,  3'd0, 4'd1, 64'h3FE0000000000000, 0);
    txn("cos60",   32'd60,  3'd1, 4'd2, 64'h3FE0000000000000, 0);
    txn("sec60",   32'd60,  3'd4, 4'd3, 64'h4000000000000000, 0);
    txn("tan45",   32'd45,  3'd2, 4'd4, 64'h3FF0000000000000, 0);
    txn("tan135",  32'd135, 3'd2, 4'd5, 64'hBFF0000000000000, 0);
    txn("sin270",  32'd270, 3'd0, 4'd6, 64'hBFF0000000000000, 0);
    txn("sin180",  32'd180, 3'd0, 4'd7, 64'h0000000000000000, 0);
    txn("sin390",  32'd390, 3'd0, 4'd8, 64'h3FE0000000000000, 0);
    txn("sin_big", 32'hFFFFFFF8, 3'd0, 4'd9, model(32'hFFFFFFF8, 0), TOL);
    txn("tan90",   32'd90,  3'd2, 4'd10, INF, 0);
    txn("sec270",  32'd270, 3'd4, 4'd11, INF, 0);
    txn("csc0",    32'd0,   3'd5, 4'd12, INF, 0);
    txn("cot180",  32'd180, 3'd3, 4'd13, INF, 0);
    txn("func6",   32'd45,  3'd6, 4'd14, NAN, 0);
    txn("func7r",  32'd5000, 3'd7, 4'd15, NAN, 0);

    // backpressure: a second request waits behind the held result
    bus.out_ready = 1'b0;
    send(32'd30, 3'd0, 4'd3, lat);
    check("bp_lat", 64'(lat), 64'd1);
    d0 = bus.out_data;
    check("bp_first", d0, 64'h3FE0000000000000);
    bus.in_angle = 32'd60;
    bus.in_func  = 3'd1;
    bus.in_tag   = 4'd4;
    bus.in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_data", bus.out_data, d0);
      check("bp_tag", 64'(bus.out_tag), 64'd3);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 64'(bus.out_valid), 64'd0);
    check("bp_idle", 64'(bus.in_ready), 64'd1);
    send(32'd60, 3'd1, 4'd4, lat);
    check("bp_second_tag", 64'(bus.out_tag), 64'd4);
    check("bp_second_data", bus.out_data, 64'h3FE0000000000000);
    drain();

    // reset while reducing drops the transaction
    bus.in_angle = 32'd1000;
    bus.in_func  = 3'd0;
    bus.in_tag   = 4'd5;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", 64'(bus.in_ready), 64'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    check("mid_no_valid", 64'(seen), 64'd0);
    check("mid_idle", 64'(bus.in_ready), 64'd1);
    txn("after_rst", 32'd1000, 3'd0, 4'd6, model(32'd1000, 0), TOL);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       ang = $urandom_range(0, 359);
        1:       ang = $urandom_range(360, 1500);
        default: ang = $urandom;
      endcase
      fn = 3'($urandom_range(0, 7));
      tg = TAG_W'($urandom_range(0, 15));
      txn("rand", ang, fn, tg, model(ang, int'(fn)), TOL);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end
endmodule
